mcu_sequencer: RTL and testbench

- Upstream instruction sequencer for the mcu datapath.
- Holds a small program RAM of instruction words, loaded by a host.
- On start, fetches instructions in order and drives them onto the mcu op/op0/op1/op2 inputs, one at a time.
- Captures the mcu out/op_err result one cycle after each issue, counts errors, and reports completion to the host.

---
 rtl/mcu_pkg.sv | 43 ++++
 rtl/mcu_prog_ram.sv | 24 ++
 rtl/mcu_sequencer.sv | 135 +++++++++++++
 tb/tb_mcu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the mcu instruction sequencer:
// opcodes, instruction-word layout helpers and FSM state codes.
package mcu_pkg;

  localparam int OPC_W = 4;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_READ  = 4'd7;
  localparam logic [3:0] OP_WRITE = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE    = 3'd0;
  localparam seq_state_t ST_FETCH   = 3'd1;
  localparam seq_state_t ST_ISSUE   = 3'd2;
  localparam seq_state_t ST_CAPTURE = 3'd3;
  localparam seq_state_t ST_DONE    = 3'd4;

  // Word layout, msb first: {op, op0, op1, op2}
  function automatic int insn_w(int ms, int os);
    return OPC_W + 2 * ms + os;
  endfunction

  function automatic int op1_lsb(int ms);
    return ms;
  endfunction

  function automatic int op0_lsb(int ms, int os);
    return ms + os;
  endfunction

  function automatic int opc_lsb(int ms, int os);
    return 2 * ms + os;
  endfunction

endpackage

// File: rtl/mcu_prog_ram.sv
// Program RAM for the sequencer: one write port,
// registered read port, contents not touched by reset.
module mcu_prog_ram #(
  parameter int aw = 6,
  parameter int dw = 56
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Runs a host-loaded program against the mcu, one
// instruction at a time, and reports errors and completion.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int op_sz       = 32,
  parameter int mem_sz      = 10,
  parameter int prog_aw     = 6,
  parameter bit halt_on_err = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               prog_we,
  input  logic [prog_aw-1:0]                 prog_addr,
  input  logic [OPC_W+2*mem_sz+op_sz-1:0]    prog_wdata,
  input  logic                               start,
  input  logic [prog_aw-1:0]                 start_pc,
  output logic                               busy,
  output logic                               done,
  output logic [7:0]                         err_cnt,
  output logic [op_sz-1:0]                   last_out,
  output logic [prog_aw-1:0]                 halt_pc,
  output logic [3:0]                         mcu_op,
  output logic [mem_sz-1:0]                  mcu_op0,
  output logic [op_sz-1:0]                   mcu_op1,
  output logic [mem_sz-1:0]                  mcu_op2,
  input  logic [op_sz-1:0]                   mcu_out,
  input  logic                               mcu_op_err
);

  localparam int IW = insn_w(mem_sz, op_sz);
  localparam int OPC_L = opc_lsb(mem_sz, op_sz);
  localparam int OP0_L = op0_lsb(mem_sz, op_sz);
  localparam int OP1_L = op1_lsb(mem_sz);

  localparam logic [prog_aw-1:0] PC_ONE  = 1;
  localparam logic [prog_aw-1:0] PC_LAST = '1;

  seq_state_t         state;
  logic [prog_aw-1:0] pc;
  logic [IW-1:0]      insn;
  logic [3:0]         opc;
  logic               issue;
  logic               ram_we;

  assign busy = (state == ST_FETCH) ||
                (state == ST_ISSUE) ||
                (state == ST_CAPTURE);
  assign done = (state == ST_DONE);

  assign ram_we = prog_we && !busy;

  mcu_prog_ram #(
    .aw (prog_aw),
    .dw (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc),
    .rdata (insn)
  );

  assign opc   = insn[OPC_L +: OPC_W];
  assign issue = (state == ST_ISSUE) && (opc != OP_HALT);

  // Outside the issue cycle the mcu sees a harmless READ of word 0
  always_comb begin
    mcu_op  = OP_READ;
    mcu_op0 = '0;
    mcu_op1 = '0;
    mcu_op2 = '0;
    if (issue) begin
      mcu_op  = opc;
      mcu_op0 = insn[OP0_L +: mem_sz];
      mcu_op1 = insn[OP1_L +: op_sz];
      mcu_op2 = insn[0 +: mem_sz];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      err_cnt  <= '0;
      last_out <= '0;
      halt_pc  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc      <= start_pc;
            err_cnt <= '0;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (opc == OP_HALT) begin
            halt_pc <= pc;
            state   <= ST_DONE;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          last_out <= mcu_out;
          if (mcu_op_err && (err_cnt != 8'hff)) begin
            err_cnt <= err_cnt + 8'd1;
          end
          if (mcu_op_err && halt_on_err) begin
            halt_pc <= pc;
            state   <= ST_DONE;
          end else if (pc == PC_LAST) begin
            halt_pc <= pc;
            state   <= ST_DONE;
          end else begin
            pc    <= pc + PC_ONE;
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Bench: two sequencers (halt_on_err 1 and 0), each driving
// its own behavioural mcu, checked through done-pulse scoreboards.
module tb_mcu_sequencer;

  typedef struct {
    logic [7:0]  err;
    logic [31:0] last;
    logic [5:0]  hpc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [55:0] prog_wdata = '0;
  logic        start = 1'b0;
  logic [5:0]  start_pc = '0;

  logic        busy [2];
  logic        done [2];
  logic [7:0]  err_cnt [2];
  logic [31:0] last_out [2];
  logic [5:0]  halt_pc [2];
  logic [3:0]  mcu_op [2];
  logic [9:0]  mcu_op0 [2];
  logic [31:0] mcu_op1 [2];
  logic [9:0]  mcu_op2 [2];
  logic [31:0] mcu_out [2];
  logic        mcu_err [2];

  int cyc = 0;
  int start_cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mem [1024];
    logic [31:0] a, b, r, wd;
    logic [9:0]  wa;
    logic        e, wr;

    mcu_sequencer #(
      .op_sz       (32),
      .mem_sz      (10),
      .prog_aw     (6),
      .halt_on_err (k == 0)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .start      (start),
      .start_pc   (start_pc),
      .busy       (busy[k]),
      .done       (done[k]),
      .err_cnt    (err_cnt[k]),
      .last_out   (last_out[k]),
      .halt_pc    (halt_pc[k]),
      .mcu_op     (mcu_op[k]),
      .mcu_op0    (mcu_op0[k]),
      .mcu_op1    (mcu_op1[k]),
      .mcu_op2    (mcu_op2[k]),
      .mcu_out    (mcu_out[k]),
      .mcu_op_err (mcu_err[k])
    );

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    // mcu: r = mem[op0] <op> mem[op1] -> mem[op2]
    always_comb begin
      a  = mem[mcu_op0[k]];
      b  = mem[mcu_op1[k][9:0]];
      r  = '0;
      e  = 1'b0;
      wr = 1'b0;
      wa = mcu_op2[k];
      case (mcu_op[k])
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a * b;
        4'd3: if (b == 0) e = 1'b1; else r = a / b;
        4'd4: r = a & b;
        4'd5: r = a | b;
        4'd6: r = a ^ b;
        4'd7: r = a;
        4'd8: r = mcu_op1[k];
        default: e = 1'b1;
      endcase
      wr = (mcu_op[k] < 4'd7 && !e) || (mcu_op[k] == 4'd8);
      if (mcu_op[k] == 4'd8) wa = mcu_op0[k];
      wd = r;
    end

    always @(posedge clk) begin
      if (wr) mem[wa] <= wd;
      mcu_out[k] <= r;
      mcu_err[k] <= e;
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, req);
  endtask

  function automatic exp_t mk(input logic [7:0] e,
                              input logic [31:0] l,
                              input logic [5:0] h,
                              input int t);
    exp_t x;
    x.err = e; x.last = l; x.hpc = h; x.lat = t;
    return x;
  endfunction

  function automatic logic [55:0] w(input logic [3:0] o,
                                    input logic [9:0] p0,
                                    input logic [31:0] p1,
                                    input logic [9:0] p2);
    return {o, p0, p1, p2};
  endfunction

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) begin : mon
        exp_t x;
        int   sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          n_chk++;
          $display("FAIL unexpected_done inst%0d actual=1 required=0",
                   k);
        end else begin
          x = (k == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("err_cnt%0d", k), 64'(err_cnt[k]),
                64'(x.err));
          check($sformatf("last_out%0d", k), 64'(last_out[k]),
                64'(x.last));
          check($sformatf("halt_pc%0d", k), 64'(halt_pc[k]),
                64'(x.hpc));
          check($sformatf("done_cycle%0d", k),
                64'(cyc - start_cyc), 64'(x.lat));
        end
      end
    end
  end

  task automatic load(input logic [5:0] a,
                      input logic [55:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = a;
    prog_wdata = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] spc);
    @(negedge clk);
    start = 1'b1;
    start_pc = spc;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    logic any;
    any = 1'b1;
    for (int i = 0; i < 300 && any; i++) begin
      @(negedge clk);
      any = busy[0] || busy[1] || done[0] || done[1];
    end
    check("run_timeout", 64'(any), 64'd0);
  endtask

  task automatic run(input logic [5:0] spc,
                     input exp_t e0, input exp_t e1);
    q0.push_back(e0);
    q1.push_back(e1);
    pulse_start(spc);
    wait_idle();
  endtask

  task automatic load_base(input logic [3:0] op);
    load(6'd0, w(4'd8, 10'd100, 32'd2, 10'd0));
    load(6'd1, w(4'd8, 10'd101, 32'd1, 10'd0));
    load(6'd2, w(op, 10'd100, 32'd101, 10'd102));
    load(6'd3, w(4'd7, 10'd102, 32'd0, 10'd0));
    load(6'd4, w(4'd15, 10'd0, 32'd0, 10'd0));
  endtask

  logic [3:0]  ops  [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  logic [31:0] outs [6] = '{32'd1, 32'd2, 32'd2, 32'd0, 32'd3, 32'd3};

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_done", 64'(done[k]), 64'd0);
      check("rst_err_cnt", 64'(err_cnt[k]), 64'd0);
      check("rst_last_out", 64'(last_out[k]), 64'd0);
      check("rst_halt_pc", 64'(halt_pc[k]), 64'd0);
      check("idle_op", 64'(mcu_op[k]), 64'd7);
      check("idle_op0", 64'(mcu_op0[k]), 64'd0);
      check("idle_op1", 64'(mcu_op1[k]), 64'd0);
      check("idle_op2", 64'(mcu_op2[k]), 64'd0);
    end

    load_base(4'd0);
    run(6'd0, mk(8'd0, 32'd3, 6'd4, 15), mk(8'd0, 32'd3, 6'd4, 15));

    for (int i = 0; i < 6; i++) begin
      load(6'd2, w(ops[i], 10'd100, 32'd101, 10'd102));
      run(6'd0, mk(8'd0, outs[i], 6'd4, 15),
          mk(8'd0, outs[i], 6'd4, 15));
    end

    load(6'd0, w(4'd8, 10'd1000, 32'd6, 10'd0));
    load(6'd1, w(4'd10, 10'd0, 32'd0, 10'd0));
    load(6'd2, w(4'd7, 10'd1000, 32'd0, 10'd0));
    load(6'd3, w(4'd15, 10'd0, 32'd0, 10'd0));
    run(6'd0, mk(8'd1, 32'd0, 6'd1, 7), mk(8'd1, 32'd6, 6'd3, 12));

    load(6'd62, w(4'd8, 10'd5, 32'd9, 10'd0));
    load(6'd63, w(4'd7, 10'd5, 32'd0, 10'd0));
    run(6'd62, mk(8'd0, 32'd9, 6'd63, 7), mk(8'd0, 32'd9, 6'd63, 7));

    load_base(4'd0);
    pulse_start(6'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("mid_rst_busy", 64'(busy[k]), 64'd0);
      check("mid_rst_done", 64'(done[k]), 64'd0);
      check("mid_rst_op", 64'(mcu_op[k]), 64'd7);
    end
    repeat (30) @(negedge clk);
    run(6'd0, mk(8'd0, 32'd3, 6'd4, 15), mk(8'd0, 32'd3, 6'd4, 15));

    q0.push_back(mk(8'd0, 32'd3, 6'd4, 15));
    q1.push_back(mk(8'd0, 32'd3, 6'd4, 15));
    pulse_start(6'd0);
    repeat (3) @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 6'd3;
    prog_wdata = w(4'd15, 10'd0, 32'd0, 10'd0);
    start = 1'b1;
    start_pc = 6'd62;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    run(6'd0, mk(8'd0, 32'd3, 6'd4, 15), mk(8'd0, 32'd3, 6'd4, 15));

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
